wide_stream_rr_arbiter: RTL

//  Packet-level round-robin arbiter sharing one 1536-bit -> 128-bit downsizer
//  (12 sub-beats per wide beat) among NUM_SRC wide AXI-Stream producers
//  (systolic output channels). Sits directly upstream of the downsizer.

---
 rtl/psys_route_pkg.sv | 13 +
 rtl/wide_stream_rr_arbiter_rr_pick.sv | 24 ++
 rtl/wide_stream_rr_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/psys_route_pkg.sv
// rtl/psys_route_pkg.sv - shared widths and state encoding for the wide-stream routing slice
package psys_route_pkg;

  localparam int DATA_W = 1536;
  localparam int SLOT_W = 128;
  localparam int LAST_W = DATA_W / SLOT_W;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/wide_stream_rr_arbiter_rr_pick.sv
// rtl/wide_stream_rr_arbiter_rr_pick.sv - rotate-priority encoder: first requester at or after ptr
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  // Scan from the farthest offset back to ptr so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_SRC]) begin
        gnt_idx = ID_W'((int'(ptr) + i) % NUM_SRC);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wide_stream_rr_arbiter.sv
// rtl/wide_stream_rr_arbiter.sv - packet-locked round-robin arbiter feeding the shared downsizer
module wide_stream_rr_arbiter
  import psys_route_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC*LAST_W-1:0] s_axis_tlast,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [LAST_W-1:0]         m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  output logic                      pkt_done
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant, rr_ptr, pick_idx;
  logic            pick_any;
  logic            pkt_end;

  rr_pick #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= pkt_end;
      if (state == IDLE && pick_any)
        grant <= pick_idx;
      if (pkt_end)
        rr_ptr <= (grant == ID_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_any) state_nxt = LOCK;
      LOCK: if (pkt_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data and tlast are always muxed from grant; only valid/ready are gated by the lock.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
    m_axis_tlast  = s_axis_tlast[int'(grant)*LAST_W +: LAST_W];
    m_axis_tid    = grant;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == LOCK) begin
      m_axis_tvalid        = s_axis_tvalid[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
    pkt_end = m_axis_tvalid & m_axis_tready & (|m_axis_tlast);
  end

endmodule
